// File: rtl/uart2wifi_pkg.sv
// Shared definitions for the UART2WiFi core: receiver states, ASCII
// constants and the ESP module response terminators.
package uart2wifi_pkg;

  localparam int OS_FACTOR = 16;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // Oldest byte first; the last element is the most recently received byte.
  localparam logic [7:0] RESP_OK  [4] = '{8'h4F, 8'h4B, CH_CR, CH_LF};
  localparam logic [7:0] RESP_ERR [7] = '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, CH_CR, CH_LF};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divide-by-OS_DIV counter that can
// be re-phased so a receiver samples relative to its own start edge.
module uart_baud_tick #(
  parameter int OS_DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(OS_DIV);
  localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst || restart || tick) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_resp_rx.sv
// 8N1 receiver for the ESP module TX line with 16x oversampling, plus a
// matcher that flags the "OK\r\n" and "ERROR\r\n" response terminators.
module uart_resp_rx
  import uart2wifi_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int OS_DIV      = (CLK_FREQ_HZ + BAUD * 8) / (BAUD * OS_FACTOR)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       resp_ok,
  output logic       resp_err,
  output logic       busy
);

  // Output protocol: rx_valid, frame_err, resp_ok and resp_err are one-cycle
  // strobes with no ready/back-pressure; a consumer that misses one loses it.

  localparam logic [3:0] OS_LAST = 4'(OS_FACTOR - 1);
  localparam logic [3:0] OS_MID  = 4'(OS_FACTOR / 2 - 1);

  logic [1:0]  sync;
  logic        rxs;
  rx_state_t   state;
  logic [3:0]  os_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tick;
  logic        restart;
  logic [55:0] hist;
  logic [55:0] hist_next;
  logic        ok_hit;
  logic        err_hit;

  assign rxs     = sync[1];
  assign restart = (state == IDLE) && !rxs;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) sync <= 2'b11;
    else      sync <= {sync[0], rx};
  end

  uart_baud_tick #(.OS_DIV(OS_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          // Mid-bit recheck of the start bit rejects short glitches.
          if (tick) begin
            if (os_cnt == OS_MID) begin
              os_cnt  <= '0;
              bit_idx <= '0;
              state   <= rxs ? IDLE : DATA;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt  <= '0;
              shreg   <= {rxs, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (os_cnt == OS_LAST) begin
              os_cnt <= '0;
              if (rxs) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                state    <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= BREAK;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Newest byte lives in hist[7:0]; matching is done on the updated history.
  assign hist_next = {hist[47:0], rx_data};

  always_comb begin
    ok_hit  = 1'b1;
    err_hit = 1'b1;
    for (int i = 0; i < 4; i++)
      if (hist_next[8*(3-i) +: 8] != RESP_OK[i]) ok_hit = 1'b0;
    for (int i = 0; i < 7; i++)
      if (hist_next[8*(6-i) +: 8] != RESP_ERR[i]) err_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist     <= '0;
      resp_ok  <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      resp_ok  <= 1'b0;
      resp_err <= 1'b0;
      if (frame_err) begin
        hist <= '0;
      end else if (rx_valid) begin
        hist     <= hist_next;
        resp_ok  <= ok_hit;
        resp_err <= err_hit;
      end
    end
  end

endmodule

// File: doc/uart_resp_rx.md
# uart_resp_rx

Serial receiver on the WiFi-module side of the UART2WiFi core. It deserialises 8N1 UART bytes arriving from the ESP module's TX pin, using 16x oversampling. It presents each byte as a one-cycle strobe and recognises the module's "OK\r\n" and "ERROR\r\n" response terminators. The core's command sequencer uses these terminators to advance, and the board LED logic uses them for status.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- BAUD, 115200, line rate.
- OS_DIV, CLK_FREQ_HZ/(BAUD*16) rounded to nearest (27 at defaults), clocks per oversample tick; must be ≥2.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising clk edge resets).
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  last received byte; held until next valid byte.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- frame_err  out  1  one-cycle strobe, stop bit sampled low.
- resp_ok  out  1  one-cycle strobe, stream tail equals "OK\r\n".
- resp_err  out  1  one-cycle strobe, stream tail equals "ERROR\r\n".
- busy  out  1  high in any state other than IDLE.

## Operation
- rx passes through a 2-flop synchroniser, which reset presets to 1. All decisions use the synchronised signal rxs.
- The tick generator counts 0..OS_DIV-1 and strobes tick on wrap. It runs freely and restarts at 0 on entry to START.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxs==0 -> START, tick count cleared.
- START: after 8 ticks, sample rxs. If 0 -> DATA, bit index 0. If 1 -> IDLE (glitch rejected, no strobe).
- DATA: sample every 16 ticks and shift LSB-first into the shift register. After bit 7 -> STOP.
- STOP: after 16 ticks, sample rxs.
  - If 1: load rx_data, pulse rx_valid, -> IDLE.
  - If 0: pulse frame_err, rx_data unchanged, -> BREAK.
- BREAK: wait for rxs==1, then -> IDLE.
- Response matcher:
  - A 7-byte history shift register updates only on rx_valid.
  - One cycle after rx_valid, it compares the last 4 bytes against 4F 4B 0D 0A, and the last 7 bytes against 45 52 52 4F 52 0D 0A.
  - Each match pulses resp_ok or resp_err respectively.
  - Both pulses can never be high together, since their last two bytes are identical but the preceding bytes differ.
- frame_err clears the history to 00, so no match spans a corrupted byte.
- No receive handshake exists. A consumer that misses a strobe loses that byte.

## Timing
- Reset values: rx_data=00, rx_valid=0, frame_err=0, resp_ok=0, resp_err=0, busy=0, FSM=IDLE, history=00.
- Let T0 be the first rising edge at which rxs==0.
- Bit n is sampled at tick 8+16(n+1) after T0. The stop bit is sampled at tick 152.
- rx_valid or frame_err is asserted on the clock edge after the stop-bit sample and lasts exactly 1 cycle.
- resp_ok and resp_err assert exactly 1 cycle after the rx_valid of the terminating 0A.
- Back-to-back bytes with zero idle are accepted: the next start edge is detected in IDLE the cycle after STOP.
- Reset mid-frame aborts the frame silently, with no strobes; the partial byte is discarded.
- Tolerated baud mismatch: ±3 % at OS_DIV≥4.

## Structure
- Package uart2wifi_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, STOP, BREAK);
  - the ASCII constants CH_CR=8'h0D, CH_LF=8'h0A;
  - the RESP_OK and RESP_ERR byte arrays;
  - the OS_FACTOR=16 localparam.
- Sub-module uart_baud_tick (parameter OS_DIV; ports clk, rst, restart, tick) is shared with the future TX path.
- The matcher stays inline.
- Estimated size: ~200 lines.

## Test plan
All scenarios use bench parameters OS_DIV=4 (64 clocks per bit).
- Single byte: send 0x41 8N1 -> rx_valid 1 cycle with rx_data=41, busy high for the frame, no frame_err.
- Stream: send "OK\r\n" back-to-back -> 4 rx_valid pulses, resp_ok exactly 1 cycle after the fourth, resp_err 0.
  - Send "ERROR\r\n" -> resp_err pulse only.
  - Send "OKX\r\n" -> neither pulse.
- Glitch: drive rx low for 20 clocks, then high -> FSM returns to IDLE, no strobes, rx_data unchanged.
- Framing error: send 0x55 with a low stop bit held low 200 clocks -> frame_err pulse, FSM in BREAK until rx rises, then 0x4B accepted normally.
  - A following "\r\n" after "O" + bad frame + "K" gives no resp_ok.
- Reset mid-frame: assert rst=0 for 1 clock during bit 4 of 0xA5 -> all outputs at reset values, no strobe.
  - The next full 0x3C is received correctly.
- Baud skew: send "OK\r\n" at bit period 62 and 66 clocks -> all bytes correct, resp_ok asserted.
